// File: rtl/digits_to_byte.sv
// Folds a most-significant-first stream of BCD digits into a 16-bit binary
// value and publishes it on a flush command with a one-cycle ready strobe.
module digits_to_byte (
   input  logic        clk,
   input  logic [3:0]  digit,
   input  logic        wen,
   input  logic        flush,
   output logic        ready,
   output logic [15:0] dout,
   input  logic        rst
);

   logic [15:0] acc_q, acc_d;
   logic [15:0] dout_q, dout_d;
   logic        ready_q, ready_d;
   logic [15:0] folded;

   // ready is a pure strobe with no back-pressure: it is high for exactly the
   // one cycle after each sampled flush, and dout is valid whenever it is high
   // (and holds that value until the next flush).
   always_comb begin
      folded = acc_q;
      if (wen && (digit <= 4'd9)) begin
         folded = (acc_q * 16'd10) + {12'd0, digit};
      end
      acc_d   = folded;
      dout_d  = dout_q;
      ready_d = 1'b0;
      if (flush) begin
         dout_d  = folded;
         ready_d = 1'b1;
         acc_d   = 16'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q   <= 16'd0;
         dout_q  <= 16'd0;
         ready_q <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         dout_q  <= dout_d;
         ready_q <= ready_d;
      end
   end

   assign ready = ready_q;
   assign dout  = dout_q;

endmodule

// File: tb/tb_digits_to_byte.sv
// Self-checking bench for digits_to_byte: directed vector table, hand-written
// multi-cycle sequences, then random traffic against a digit-queue model.
module tb_digits_to_byte;

   logic        clk;
   logic [3:0]  digit;
   logic        wen;
   logic        flush;
   logic        ready;
   logic [15:0] dout;
   logic        rst;

   int total = 0;
   int bad   = 0;

   digits_to_byte dut (
      .clk   (clk),
      .digit (digit),
      .wen   (wen),
      .flush (flush),
      .ready (ready),
      .dout  (dout),
      .rst   (rst)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        r;
      logic        w;
      logic        f;
      logic [3:0]  d;
      logic        er;
      logic [15:0] ed;
   } vec_t;

   vec_t vecs[$];

   task automatic step(input logic r, input logic w, input logic f, input logic [3:0] d);
      @(negedge clk);
      rst   = r;
      wen   = w;
      flush = f;
      digit = d;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic er, input logic [15:0] ed);
      total++;
      if (ready !== er || dout !== ed) begin
         bad++;
         $display("FAIL %s: got ready=%0b dout=%0d, required ready=%0b dout=%0d",
                  name, ready, dout, er, ed);
      end
   endtask

   function automatic void add(input logic r, input logic w, input logic f,
                               input logic [3:0] d, input logic er, input logic [15:0] ed);
      vec_t v;
      v.r = r; v.w = w; v.f = f; v.d = d; v.er = er; v.ed = ed;
      vecs.push_back(v);
   endfunction

   // Reference: digits of the current number are kept as a list and the value
   // is evaluated as a decimal number modulo 2^16 only when it is flushed.
   int          num_q[$];
   logic        m_ready;
   logic [15:0] m_dout;

   function automatic logic [15:0] decimal_value();
      int v = 0;
      foreach (num_q[i]) v = (v * 10 + num_q[i]) % 65536;
      return v[15:0];
   endfunction

   initial begin
      rst = 1'b1; wen = 1'b0; flush = 1'b0; digit = 4'd0;

      // Directed table (r, w, f, digit, expected ready, expected dout).
      add(1, 0, 0, 0, 0, 0);
      add(0, 1, 0, 1, 0, 0);
      add(0, 1, 0, 2, 0, 0);
      add(0, 1, 0, 3, 0, 0);
      add(0, 0, 1, 0, 1, 123);
      add(0, 0, 0, 0, 0, 123);
      add(0, 1, 0, 4, 0, 123);
      add(0, 0, 1, 0, 1, 4);
      add(0, 1, 0, 6, 0, 4);
      add(0, 1, 0, 5, 0, 4);
      add(0, 1, 0, 5, 0, 4);
      add(0, 1, 0, 3, 0, 4);
      add(0, 1, 0, 6, 0, 4);
      add(0, 0, 1, 0, 1, 0);
      add(0, 1, 0, 6, 0, 0);
      add(0, 1, 0, 5, 0, 0);
      add(0, 1, 0, 5, 0, 0);
      add(0, 1, 0, 3, 0, 0);
      add(0, 1, 0, 5, 0, 0);
      add(0, 0, 1, 0, 1, 65535);
      add(0, 0, 1, 0, 1, 0);
      add(0, 1, 0, 4, 0, 0);
      add(0, 1, 0, 12, 0, 0);
      add(0, 1, 0, 2, 0, 0);
      add(0, 0, 1, 0, 1, 42);
      add(0, 1, 0, 1, 0, 42);
      add(0, 1, 1, 9, 1, 19);
      add(0, 0, 0, 0, 0, 19);
      add(0, 1, 0, 2, 0, 19);
      add(0, 1, 1, 15, 1, 2);

      foreach (vecs[i]) begin
         step(vecs[i].r, vecs[i].w, vecs[i].f, vecs[i].d);
         check($sformatf("vec%0d", i), vecs[i].er, vecs[i].ed);
      end

      // Flush held for three cycles after 7,8.
      step(0, 1, 0, 7);
      step(0, 1, 0, 8);
      step(0, 0, 1, 0); check("hold_flush1", 1, 78);
      step(0, 0, 1, 0); check("hold_flush2", 1, 0);
      step(0, 0, 1, 0); check("hold_flush3", 1, 0);
      step(0, 0, 0, 0); check("hold_flush_end", 0, 0);

      // Reset mid-number overrides a simultaneous digit and flush.
      step(0, 1, 0, 5);
      step(0, 1, 0, 5);
      step(0, 0, 1, 0); check("pre_rst", 1, 55);
      step(0, 1, 0, 5);
      step(0, 1, 0, 5);
      step(1, 1, 1, 9); check("during_rst", 0, 0);
      step(0, 1, 1, 3); check("after_rst", 1, 3);

      // Random traffic against the reference model.
      step(1, 0, 0, 0);
      num_q.delete();
      m_ready = 1'b0;
      m_dout  = 16'd0;
      check("rand_reset", m_ready, m_dout);
      for (int n = 0; n < 400; n++) begin
         logic       r, w, f;
         logic [3:0] d;
         r = ($urandom_range(0, 39) == 0);
         w = ($urandom_range(0, 3) != 0);
         f = ($urandom_range(0, 5) == 0);
         d = 4'($urandom_range(0, 15));
         step(r, w, f, d);
         if (r) begin
            num_q.delete();
            m_ready = 1'b0;
            m_dout  = 16'd0;
         end else begin
            if (w && d <= 9) num_q.push_back(int'(d));
            m_ready = f;
            if (f) begin
               m_dout = decimal_value();
               num_q.delete();
            end
         end
         check($sformatf("rand%0d", n), m_ready, m_dout);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/digits_to_byte.md
# digits_to_byte

Accumulates a stream of BCD decimal digits, most significant first, into a 16-bit binary value. On a flush command it publishes the value with a one-cycle `ready` strobe and clears the accumulator for the next number. It sits between a character/digit decoder (e.g. the UART ASCII front end) and downstream arithmetic logic that consumes binary operands.

## Interface
Parameters: none (widths fixed: 4-bit digit, 16-bit result).

Ports (declaration order: clk, digit, wen, flush, ready, dout, rst, so 6-port positional instantiations still map):
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset. One clock; reset is synchronous and active-high. A floating/undriven rst must behave as deasserted.
- digit  input  4  decimal digit 0–9 (BCD), sampled when wen=1.
- wen  input  1  digit write enable, sampled each rising edge.
- flush  input  1  end-of-number command, sampled each rising edge.
- ready  output  1  registered one-cycle strobe: dout just updated with a completed number.
- dout  output  16  last completed number (unsigned binary), held between flushes.

## Operation
- Internal 16-bit accumulator `acc`.
- Rising edge with wen=1, flush=0, digit ≤ 9: acc ← (acc×10 + digit) mod 2^16.
- Rising edge with wen=1, digit > 9: digit ignored, acc unchanged, no error flag.
- Rising edge with flush=1, wen=0: dout ← acc; ready ← 1; acc ← 0.
- Rising edge with flush=1 and wen=1 (valid digit): digit is folded in first. dout ← (acc×10 + digit) mod 2^16; ready ← 1; acc ← 0.
- Flush with acc=0 (no digits since last flush/reset): dout ← 0, ready pulses. This is a legal "number 0".
- Every cycle without flush: ready ← 0; dout holds.
- Overflow: arithmetic wraps modulo 65536. No saturation, no flag.
- flush is level-sampled. Holding it N cycles yields N strobes: the first carries the value, the rest carry 0.
- Reset (rst=1 at an edge, overrides all inputs): acc=0, dout=0, ready=0. Reset mid-number discards the partial accumulation.

## Timing
- Single clock domain. Inputs must meet setup to the rising edge; each high sample of wen consumes exactly one digit.
- Digit write latency: acc updated at the sampling edge and visible to the next digit immediately; no throughput limit (one digit per cycle).
- Flush latency: dout and ready change at the same edge that samples flush (registered outputs, valid right after that edge). ready is high for exactly one clock per sampled flush.
- A digit written in the cycle right after a flush starts a new number; back-to-back flush/digit cycles are legal.
- No combinational path from inputs to outputs.
- Reset values: ready=0, dout=16'd0.

## Test plan
- Reset then digits 1,2,3 (one wen cycle each), then flush → ready pulses one cycle, dout=123; next cycle ready=0, dout stays 123.
- After the above, digit 4 then flush → dout=4 (accumulator was cleared), single ready pulse.
- Digits 6,5,5,3,6 + flush → dout=65536 mod 65536=0. Digits 6,5,5,3,5 + flush → dout=65535.
- Flush with no digits → dout=0, ready pulse. Flush held 3 cycles after digits 7,8 → ready high 3 cycles; dout=78 on first edge, then 0.
- Digit 12 with wen between digits 4 and 2 → ignored; flush gives dout=42. Simultaneous wen(digit 9)+flush after digit 1 → dout=19.
- Digits 5,5, assert rst one cycle, then digit 3 + flush → dout=3; during rst, dout=0 and ready=0.
